// File: rtl/sub_bytes_engine_if.sv
// Request/response bundle for sub_bytes_engine.
// With SUB_BYTES_INV_EN defined, an inverse-select line travels with start.
interface sub_bytes_engine_if;
    logic         start;
    logic [127:0] data_in;
`ifdef SUB_BYTES_INV_EN
    logic         inverse;
`endif
    logic         busy;
    logic         data_valid;
    logic [127:0] data_out;

`ifdef SUB_BYTES_INV_EN
    modport master (output start, output data_in, output inverse,
                    input busy, input data_valid, input data_out);
    modport slave  (input start, input data_in, input inverse,
                    output busy, output data_valid, output data_out);
`else
    modport master (output start, output data_in,
                    input busy, input data_valid, input data_out);
    modport slave  (input start, input data_in,
                    output busy, output data_valid, output data_out);
`endif
endinterface

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes: LANES bytes per cycle through combinational S-box lanes.
// Optional macro SUB_BYTES_INV_EN adds per-job selectable inverse S-box lanes.

// Multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1, computed as a^254 (0 maps to 0).
module gf_inverse (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;

    always_comb begin
        x2   = gf_mul(a_i, a_i);
        x3   = gf_mul(x2, a_i);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        y_o  = gf_mul(x252, x2);
    end
endmodule

// Forward S-box: field inverse followed by the affine transform.
module s_box_lookup (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    logic [7:0] inv;

    gf_inverse u_inv (
        .a_i (a_i),
        .y_o (inv)
    );

    assign y_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

`ifdef SUB_BYTES_INV_EN
// Inverse S-box: inverse affine transform followed by the field inverse.
module inv_s_box_lookup (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    logic [7:0] aff;

    assign aff = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;

    gf_inverse u_inv (
        .a_i (aff),
        .y_o (y_o)
    );
endmodule
`endif

module sub_bytes_engine #(
    parameter int unsigned LANES = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    sub_bytes_engine_if.slave  bus
);
    localparam int unsigned Steps = 16 / LANES;
    localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    // Byte 0 lives in the top slice, so byte i sits at element 15-i.
    logic [15:0][7:0] work_q, work_d;
    logic [15:0][7:0] out_q, out_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic [3:0]       lane_idx [LANES];
    logic [7:0]       lane_in  [LANES];
    logic [7:0]       lane_out [LANES];
    logic [7:0]       fwd_out  [LANES];
`ifdef SUB_BYTES_INV_EN
    logic             inv_q, inv_d;
    logic [7:0]       inv_out  [LANES];
`endif

    always_comb begin
        for (int l = 0; l < int'(LANES); l++) begin
            lane_idx[l] = 4'(15 - (int'(cnt_q) * int'(LANES) + l));
            lane_in[l]  = work_q[lane_idx[l]];
        end
    end

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        s_box_lookup u_fwd (
            .a_i (lane_in[g]),
            .y_o (fwd_out[g])
        );
`ifdef SUB_BYTES_INV_EN
        inv_s_box_lookup u_inv (
            .a_i (lane_in[g]),
            .y_o (inv_out[g])
        );
        assign lane_out[g] = inv_q ? inv_out[g] : fwd_out[g];
`else
        assign lane_out[g] = fwd_out[g];
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        out_d   = out_q;
        valid_d = 1'b0;
        busy_d  = (state_q != StIdle);
`ifdef SUB_BYTES_INV_EN
        inv_d   = inv_q;
`endif
        unique case (state_q)
            StIdle: begin
                // busy_q still covers the valid cycle, so a start there is dropped.
                if (bus.start && !busy_q) begin
                    work_d  = bus.data_in;
                    cnt_d   = '0;
                    state_d = StRun;
`ifdef SUB_BYTES_INV_EN
                    inv_d   = bus.inverse;
`endif
                end
            end
            StRun: begin
                for (int l = 0; l < int'(LANES); l++) begin
                    work_d[lane_idx[l]] = lane_out[l];
                end
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                out_d   = work_q;
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            work_q  <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef SUB_BYTES_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
`ifdef SUB_BYTES_INV_EN
            inv_q   <= inv_d;
`endif
        end
    end

    assign bus.busy       = busy_q;
    assign bus.data_valid = valid_q;
    assign bus.data_out   = out_q;
endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: LANES=4 and LANES=1 instances driven in lockstep,
// checked against a table-driven S-box model built from the field definition.
module tb_sub_bytes_engine;
`ifdef SUB_BYTES_INV_EN
    localparam bit InvEn = 1'b1;
`else
    localparam bit InvEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic [127:0] data_in;
`ifdef SUB_BYTES_INV_EN
    logic         inverse;
`endif

    always #5 clk = ~clk;

    sub_bytes_engine_if bus4 ();
    sub_bytes_engine_if bus1 ();

    assign bus4.start   = start;
    assign bus4.data_in = data_in;
    assign bus1.start   = start;
    assign bus1.data_in = data_in;
`ifdef SUB_BYTES_INV_EN
    assign bus4.inverse = inverse;
    assign bus1.inverse = inverse;
`endif

    sub_bytes_engine #(.LANES(4)) u_dut4 (.clk(clk), .n_rst(n_rst), .bus(bus4));
    sub_bytes_engine #(.LANES(1)) u_dut1 (.clk(clk), .n_rst(n_rst), .bus(bus1));

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] prev_out;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse by exhaustive search, then the bitwise affine map with constant 0x63.
    task automatic build_tables();
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] y = 8'h00;
            logic [7:0] s;
            for (int k = 1; k < 256; k++) if (gmul(8'(x), 8'(k)) == 8'h01) y = 8'(k);
            for (int i = 0; i < 8; i++)
                s[i] = y[i] ^ y[(i + 4) % 8] ^ y[(i + 5) % 8] ^ y[(i + 6) % 8] ^ y[(i + 7) % 8] ^ c[i];
            sbox[x] = s;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input bit inv);
        logic [127:0] r;
        for (int b = 0; b < 16; b++)
            r[8*b +: 8] = inv ? isbox[d[8*b +: 8]] : sbox[d[8*b +: 8]];
        return r;
    endfunction

    // extra_cyc > 0 raises a second start (extra_d) during that cycle of the job.
    task automatic run_job(input logic [127:0] d, input bit inv, input int extra_cyc,
                           input logic [127:0] extra_d, input bit flip_inv);
        logic [127:0] exp;
        int v4 = -1, v1 = -1, p4 = 0, p1 = 0, bad4 = 0, bad1 = 0, hold4 = 0, hold1 = 0;
        exp = model(d, InvEn && inv);
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
`ifdef SUB_BYTES_INV_EN
        inverse = inv;
`endif
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            start   = 1'b0;
            data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (bus4.data_valid) begin p4++; if (v4 < 0) v4 = c; end
            if (bus1.data_valid) begin p1++; if (v1 < 0) v1 = c; end
            if (bus4.busy !== (c >= 1 && c <= 5)) bad4++;
            if (bus1.busy !== (c >= 1 && c <= 17)) bad1++;
            if (v4 < 0 && bus4.data_out !== prev_out) hold4++;
            if (v1 < 0 && bus1.data_out !== prev_out) hold1++;
            if (c == extra_cyc) begin start = 1'b1; data_in = extra_d; end
`ifdef SUB_BYTES_INV_EN
            if (flip_inv && c == 2) inverse = ~inverse;
`else
            if (flip_inv && c == 2) data_in = ~data_in;
`endif
        end
        check("lat4", 128'(v4), 128'd5);
        check("lat1", 128'(v1), 128'd17);
        check("pulses4", 128'(p4), 128'd1);
        check("pulses1", 128'(p1), 128'd1);
        check("busy4", 128'(bad4), 128'd0);
        check("busy1", 128'(bad1), 128'd0);
        check("hold4", 128'(hold4), 128'd0);
        check("hold1", 128'(hold1), 128'd0);
        check("data4", bus4.data_out, exp);
        check("data1", bus1.data_out, exp);
        prev_out = exp;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy4"}, 128'(bus4.busy), 128'd0);
        check({tag, "_valid4"}, 128'(bus4.data_valid), 128'd0);
        check({tag, "_out4"}, bus4.data_out, 128'd0);
        check({tag, "_busy1"}, 128'(bus1.busy), 128'd0);
        check({tag, "_valid1"}, 128'(bus1.data_valid), 128'd0);
        check({tag, "_out1"}, bus1.data_out, 128'd0);
    endtask

    task automatic reset_mid_job(input logic [127:0] d);
        int pulses = 0;
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 n_rst = 1'b0;
        #1 check_reset_values("midrst");
        repeat (3) @(negedge clk);
        n_rst    = 1'b1;
        prev_out = '0;
        repeat (25) begin
            @(negedge clk);
            if (bus4.data_valid || bus1.data_valid) pulses++;
        end
        check("midrst_nopulse", 128'(pulses), 128'd0);
    endtask

    initial begin
        int bad;
        build_tables();
        n_rst    = 1'b0;
        start    = 1'b0;
        data_in  = '0;
        prev_out = '0;
`ifdef SUB_BYTES_INV_EN
        inverse  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        n_rst = 1'b1;
        bad   = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus4.busy || bus4.data_valid || bus4.data_out != 0) bad++;
            if (bus1.busy || bus1.data_valid || bus1.data_out != 0) bad++;
        end
        check("idle20", 128'(bad), 128'd0);

        run_job(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 0, '0, 1'b0);
        check("fips_vec", bus4.data_out, 128'hd42711aee0bf98f1b8b45de51e415230);

        run_job(128'h000153ff000000000000000000000000, 1'b0, 0, '0, 1'b0);
        check("corner_vec", bus1.data_out, 128'h637ced16636363636363636363636363);

        // Second start mid-job, then a start in the LANES=4 valid cycle.
        run_job({4{$urandom()}}, 1'b0, 2, {4{$urandom()}}, 1'b0);
        run_job({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 5,
                {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);

        reset_mid_job({$urandom(), $urandom(), $urandom(), $urandom()});
        run_job({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 0, '0, 1'b0);

        for (int j = 0; j < 6; j++)
            run_job({$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                    0, '0, 1'($urandom_range(0, 1)));

`ifdef SUB_BYTES_INV_EN
        run_job(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 0, '0, 1'b1);
        check("inv_vec", bus4.data_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
